// File: rtl/shift_add_multiplier_32bit_pkg.sv
// -----------------------------------------------------------------------------
// mul_pkg
// Shared types and sizing for the shift-and-add multiplier.
//   state_e    : control FSM states (IDLE, RUN, DONE)
//   MUL_SIZE   : operand width (the adder instance is fixed at 32 bits)
//   MUL_ITER   : number of RUN iterations per product
//   MUL_CNT_W  : width of the iteration counter
// -----------------------------------------------------------------------------
package mul_pkg;

    localparam int unsigned MUL_SIZE  = 32;
    localparam int unsigned MUL_ITER  = 32;
    localparam int unsigned MUL_CNT_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage : mul_pkg

// File: rtl/shift_add_multiplier_32bit_if.sv
// -----------------------------------------------------------------------------
// shift_add_multiplier_32bit_if
// Request/response bundle between the issuing datapath and the multiplier.
//   start : request, sampled only when the multiplier is not busy
//   a, b  : multiplicand / multiplier, captured on an accepted start
//   busy  : high while iterating
//   done  : one-cycle pulse when p becomes valid
//   p     : 64-bit product, held until the next accepted start
// Modports: master = issuer, slave = multiplier.
// -----------------------------------------------------------------------------
interface shift_add_multiplier_32bit_if;
    import mul_pkg::*;

    logic                    start;
    logic [MUL_SIZE-1:0]     a;
    logic [MUL_SIZE-1:0]     b;
    logic                    busy;
    logic                    done;
    logic [2*MUL_SIZE-1:0]   p;

    modport master (
        output start, a, b,
        input  busy, done, p
    );

    modport slave (
        input  start, a, b,
        output busy, done, p
    );

endinterface : shift_add_multiplier_32bit_if

// File: rtl/shift_add_multiplier_32bit_adder.sv
// -----------------------------------------------------------------------------
// prefix_adder_32bit
// 32-bit Kogge-Stone parallel-prefix adder (five prefix levels).
//   a_i, b_i : addends
//   cin_i    : carry in
//   sum_o    : 32-bit sum
//   cout_o   : carry out of bit 31
// -----------------------------------------------------------------------------
module prefix_adder_32bit (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        cin_i,
    output logic [31:0] sum_o,
    output logic        cout_o
);

    logic [31:0] g0, p0, g1, p1, g2, p2, g3, p3, g4, p4, g5, p5;
    logic [31:0] carry;

    // Each level doubles the span of group generate/propagate; the OR-mask
    // keeps propagate intact for bits whose span already reaches bit 0.
    always_comb begin
        g0 = a_i & b_i;
        p0 = a_i ^ b_i;
        g1 = g0 | (p0 & (g0 << 1));
        p1 = p0 & ((p0 << 1) | 32'h0000_0001);
        g2 = g1 | (p1 & (g1 << 2));
        p2 = p1 & ((p1 << 2) | 32'h0000_0003);
        g3 = g2 | (p2 & (g2 << 4));
        p3 = p2 & ((p2 << 4) | 32'h0000_000F);
        g4 = g3 | (p3 & (g3 << 8));
        p4 = p3 & ((p3 << 8) | 32'h0000_00FF);
        g5 = g4 | (p4 & (g4 << 16));
        p5 = p4 & ((p4 << 16) | 32'h0000_FFFF);
        // carry[i] is the carry out of bit i, including cin
        carry  = g5 | (p5 & {32{cin_i}});
        sum_o  = p0 ^ {carry[30:0], cin_i};
        cout_o = carry[31];
    end

endmodule : prefix_adder_32bit

// File: rtl/shift_add_multiplier_32bit.sv
// -----------------------------------------------------------------------------
// shift_add_multiplier_32bit
// Multi-cycle 32x32 -> 64-bit unsigned radix-2 shift-and-add multiplier,
// one iteration per clock around a 32-bit prefix adder.
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   mul   : slave side of shift_add_multiplier_32bit_if
//           (start, a, b in; busy, done, p out; all outputs registered)
// Build option: MUL_ZERO_SKIP_EN -- when defined, an accepted start with a
// zero operand goes straight to DONE with p=0 (latency 1).
// -----------------------------------------------------------------------------
module shift_add_multiplier_32bit
    import mul_pkg::*;
#(
    parameter int unsigned SIZE = MUL_SIZE,
    parameter int unsigned ITER = SIZE
) (
    input  logic                          clk,
    input  logic                          reset,
    shift_add_multiplier_32bit_if.slave   mul
);

    state_e                 state_q, state_d;
    logic [MUL_CNT_W-1:0]   cnt_q, cnt_d;
    logic [SIZE-1:0]        mcand_q, mcand_d;
    logic [SIZE-1:0]        hi_q, hi_d;
    logic [SIZE-1:0]        lo_q, lo_d;
    logic [2*SIZE-1:0]      p_q, p_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic [SIZE-1:0]        add_b;
    logic [SIZE-1:0]        add_sum;
    logic                   add_cout;

    // Add stage: running high partial product plus the gated multiplicand
    assign add_b = lo_q[0] ? mcand_q : '0;

    prefix_adder_32bit u_adder (
        .a_i    (hi_q),
        .b_i    (add_b),
        .cin_i  (1'b0),
        .sum_o  (add_sum),
        .cout_o (add_cout)
    );

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mcand_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            p_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mcand_q <= mcand_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            p_q     <= p_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state, datapath update and registered-output decode
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mcand_d = mcand_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        p_d     = p_q;

        case (state_q)
            IDLE, DONE: begin
                if (state_q == DONE) begin
                    state_d = IDLE;
                end
                if (mul.start) begin
                    mcand_d = mul.a;
                    lo_d    = mul.b;
                    hi_d    = '0;
                    cnt_d   = MUL_CNT_W'(ITER - 1);
                    state_d = RUN;
`ifdef MUL_ZERO_SKIP_EN
                    if ((mul.a == '0) || (mul.b == '0)) begin
                        p_d     = '0;
                        state_d = DONE;
                    end
`endif
                end
            end

            RUN: begin
                // {hi,lo} <= {cout, sum, lo[31:1]}: the 33-bit sum shifts right
                hi_d = {add_cout, add_sum[SIZE-1:1]};
                lo_d = {add_sum[0], lo_q[SIZE-1:1]};
                if (cnt_q == '0) begin
                    p_d     = {add_cout, add_sum, lo_q[SIZE-1:1]};
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - MUL_CNT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    assign mul.busy = busy_q;
    assign mul.done = done_q;
    assign mul.p    = p_q;

endmodule : shift_add_multiplier_32bit
